// File: rtl/video_stream_selector_if.sv
// Bundle of the selector's request, per-channel pixel inputs and display-side outputs.
// master = the side driving the source streams and sel, slave = the selector itself.
interface video_stream_selector_if #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 16,
    parameter int SEL_W  = 4
);
    logic [SEL_W-1:0]         sel;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_vsync;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_vsync;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         active_sel;
    logic                     pending;
    logic                     sel_err;

    modport master (
        output sel, in_valid, in_vsync, in_data,
        input  out_valid, out_vsync, out_data, active_sel, pending, sel_err
    );

    modport slave (
        input  sel, in_valid, in_vsync, in_data,
        output out_valid, out_vsync, out_data, active_sel, pending, sel_err
    );
endinterface

// File: rtl/video_stream_selector.sv
// Frame-aligned video source selector: defers a source change to the next SOF of the requested
// channel, expands/inverts binary channels. Optional forced switch on timeout: SEL_TIMEOUT_EN.
module video_stream_selector #(
    parameter int                NUM_CH      = 8,
    parameter int                DATA_W      = 16,
    parameter int                SEL_W       = 4,
    parameter logic [NUM_CH-1:0] BIN_MASK    = 8'b1111_1000,
    parameter int                DEFAULT_CH  = 0,
    parameter int                TIMEOUT_CYC = 1048576
) (
    input  logic                   clk,
    input  logic                   rst,
    video_stream_selector_if.slave bus
);
    localparam int               N_EXT    = 1 << SEL_W;
    localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(DEFAULT_CH);

    typedef enum logic {LOCKED = 1'b0, PENDING = 1'b1} state_t;

    // out_valid qualifies out_data/out_vsync on the same cycle; there is no backpressure,
    // so every cycle with out_valid=1 carries one pixel that the display must accept.
    state_t              state_q, state_d;
    logic [SEL_W-1:0]    pend_sel_q, pend_sel_d;
    logic [SEL_W-1:0]    active_sel_q, active_sel_d;
    logic [NUM_CH-1:0]   vsync_d_q;
    logic                out_valid_q, out_valid_d;
    logic                out_vsync_q, out_vsync_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                sel_err_q, sel_err_d;

    logic                sel_valid;
    logic                do_switch;
    logic                force_switch;
    logic [SEL_W-1:0]    eff;
    logic [N_EXT-1:0]    valid_ext, vsync_ext, sof_ext, bin_ext;
    logic [DATA_W-1:0]   data_ext [N_EXT];

    // Channel vectors padded to the full sel range so any sel value indexes safely.
    for (genvar i = 0; i < N_EXT; i++) begin : g_ext
        if (i < NUM_CH) begin : g_ch
            assign valid_ext[i] = bus.in_valid[i];
            assign vsync_ext[i] = bus.in_vsync[i];
            assign sof_ext[i]   = bus.in_vsync[i] & ~vsync_d_q[i];
            assign bin_ext[i]   = BIN_MASK[i];
            assign data_ext[i]  = bus.in_data[i*DATA_W +: DATA_W];
        end else begin : g_pad
            assign valid_ext[i] = 1'b0;
            assign vsync_ext[i] = 1'b0;
            assign sof_ext[i]   = 1'b0;
            assign bin_ext[i]   = 1'b0;
            assign data_ext[i]  = '0;
        end
    end

    assign sel_valid = ({1'b0, bus.sel} < NUM_CH_W);

`ifdef SEL_TIMEOUT_EN
    localparam int            TW         = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] timer_q, timer_d;

    assign force_switch = (timer_q == TIMER_LAST);

    // Timer counts only while the same request keeps waiting; entry or retarget restarts it.
    always_comb begin
        timer_d = '0;
        if (state_q == PENDING && state_d == PENDING && pend_sel_d == pend_sel_q)
            timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
    end
`else
    assign force_switch = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOCKED;
            pend_sel_q   <= DEF_SEL;
            active_sel_q <= DEF_SEL;
            vsync_d_q    <= '0;
            out_valid_q  <= 1'b0;
            out_vsync_q  <= 1'b0;
            out_data_q   <= '0;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_sel_q   <= pend_sel_d;
            active_sel_q <= active_sel_d;
            vsync_d_q    <= bus.in_vsync;
            out_valid_q  <= out_valid_d;
            out_vsync_q  <= out_vsync_d;
            out_data_q   <= out_data_d;
            sel_err_q    <= sel_err_d;
        end
    end

    // In PENDING: cancel beats retarget beats SOF/timeout switch; an invalid sel just waits.
    always_comb begin
        state_d      = state_q;
        pend_sel_d   = pend_sel_q;
        active_sel_d = active_sel_q;
        do_switch    = 1'b0;
        case (state_q)
            LOCKED: begin
                if (sel_valid && bus.sel != active_sel_q) begin
                    state_d    = PENDING;
                    pend_sel_d = bus.sel;
                end
            end
            PENDING: begin
                if (bus.sel == active_sel_q) begin
                    state_d = LOCKED;
                end else if (sel_valid && bus.sel != pend_sel_q) begin
                    pend_sel_d = bus.sel;
                end else if (sof_ext[pend_sel_q] || force_switch) begin
                    do_switch    = 1'b1;
                    active_sel_d = pend_sel_q;
                    state_d      = LOCKED;
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    // The switching cycle already forwards the new source so its SOF pixel is not lost.
    always_comb begin
        eff         = do_switch ? pend_sel_q : active_sel_q;
        out_valid_d = valid_ext[eff];
        out_vsync_d = vsync_ext[eff];
        out_data_d  = bin_ext[eff] ? ~{DATA_W{data_ext[eff][0]}} : data_ext[eff];
        sel_err_d   = ~sel_valid;
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_vsync  = out_vsync_q;
    assign bus.out_data   = out_data_q;
    assign bus.active_sel = active_sel_q;
    assign bus.pending    = (state_q == PENDING);
    assign bus.sel_err    = sel_err_q;
endmodule

// File: tb/tb_video_stream_selector.sv
// Self-checking bench for video_stream_selector: directed scenarios plus randomized traffic
// compared against a frame-level reference model of the source-switch rules.
module tb_video_stream_selector;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 16;
  localparam int SEL_W  = 4;
  localparam logic [NUM_CH-1:0] BIN_MASK = 8'b1111_1000;
  localparam int TO_CYC = 16;
`ifdef SEL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  // reference model: current source, outstanding request and how long it has waited
  int m_active, m_pend, m_wait_cnt;
  bit m_waiting, m_err;
  bit m_prev_vs[NUM_CH];
  logic [DATA_W+1:0] exp_q[$];

  video_stream_selector_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) vif ();

  video_stream_selector #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W), .BIN_MASK(BIN_MASK),
    .DEFAULT_CH(0), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(vif)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W+1:0] chan_out(int c);
    logic [DATA_W-1:0] d;
    d = vif.in_data[c*DATA_W +: DATA_W];
    if (BIN_MASK[c]) d = d[0] ? 16'h0000 : 16'hFFFF;
    return {vif.in_valid[c], vif.in_vsync[c], d};
  endfunction

  task automatic model_reset();
    m_active = 0; m_pend = 0; m_wait_cnt = 0; m_waiting = 0; m_err = 0;
    foreach (m_prev_vs[i]) m_prev_vs[i] = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  task automatic model_step();
    int s, src;
    bit ok;
    bit sof[NUM_CH];
    s = int'(vif.sel);
    ok = (s < NUM_CH);
    src = m_active;
    for (int i = 0; i < NUM_CH; i++) sof[i] = vif.in_vsync[i] && !m_prev_vs[i];
    if (!m_waiting) begin
      if (ok && s != m_active) begin m_waiting = 1; m_pend = s; m_wait_cnt = 0; end
    end else if (s == m_active) begin
      m_waiting = 0;
    end else if (ok && s != m_pend) begin
      m_pend = s; m_wait_cnt = 0;
    end else if (sof[m_pend] || (TO_EN && m_wait_cnt == TO_CYC - 1)) begin
      m_active = m_pend; src = m_pend; m_waiting = 0;
    end else begin
      m_wait_cnt++;
    end
    exp_q.push_back(chan_out(src));
    m_err = !ok;
    for (int i = 0; i < NUM_CH; i++) m_prev_vs[i] = vif.in_vsync[i];
  endtask

  function automatic logic [DATA_W+1:0] latest_exp();
    while (exp_q.size() > 1) void'(exp_q.pop_front());
    return exp_q[0];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic drive_idle();
    vif.in_valid = '0;
    vif.in_vsync = '0;
    vif.in_data  = '0;
  endtask

  task automatic set_ch(int c, bit v, bit vs, logic [DATA_W-1:0] d);
    vif.in_valid[c] = v;
    vif.in_vsync[c] = vs;
    vif.in_data[c*DATA_W +: DATA_W] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vif.sel = 4'($urandom_range(0, 9));
    vif.in_valid = NUM_CH'($urandom);
    vif.in_vsync = NUM_CH'($urandom);
    vif.in_data = {$urandom, $urandom, $urandom, $urandom};
    #1 model_reset();
    repeat (2) tick();
    total++; if (vif.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", vif.out_valid); end
    total++; if (vif.out_vsync !== 1'b0) begin bad++; $display("FAIL reset_vsync: got %b exp 0", vif.out_vsync); end
    total++; if (vif.out_data !== 16'h0) begin bad++; $display("FAIL reset_data: got %h exp 0000", vif.out_data); end
    total++; if (vif.active_sel !== 4'd0) begin bad++; $display("FAIL reset_active: got %0d exp 0", vif.active_sel); end
    total++; if (vif.pending !== 1'b0) begin bad++; $display("FAIL reset_pending: got %b exp 0", vif.pending); end
    total++; if (vif.sel_err !== 1'b0) begin bad++; $display("FAIL reset_sel_err: got %b exp 0", vif.sel_err); end
    drive_idle();
    vif.sel = 4'd0;
    set_ch(0, 1'b1, 1'b0, 16'h1234);
    rst = 1'b0;
    tick();
    total++; if (vif.out_data !== 16'h1234) begin bad++; $display("FAIL release_data: got %h exp 1234", vif.out_data); end
    total++; if (vif.out_valid !== 1'b1) begin bad++; $display("FAIL release_valid: got %b exp 1", vif.out_valid); end
  endtask

  task automatic test_switch();
    logic [DATA_W+1:0] e;
    vif.sel = 4'd2;
    tick();
    e = latest_exp();
    total++; if (vif.pending !== 1'b1) begin bad++; $display("FAIL switch_pending: got %b exp 1", vif.pending); end
    total++; if (vif.active_sel !== 4'd0) begin bad++; $display("FAIL switch_wait_active: got %0d exp 0", vif.active_sel); end
    total++; if (vif.out_data !== e[DATA_W-1:0] || vif.out_data !== 16'h1234) begin bad++; $display("FAIL switch_wait_data: got %h exp %h", vif.out_data, e[DATA_W-1:0]); end
    set_ch(2, 1'b1, 1'b1, 16'hABCD);
    tick();
    total++; if (vif.active_sel !== 4'd2 || vif.pending !== 1'b0) begin bad++; $display("FAIL switch_sof: got active=%0d pending=%b exp active=2 pending=0", vif.active_sel, vif.pending); end
    total++; if (vif.out_data !== 16'hABCD || vif.out_vsync !== 1'b1) begin bad++; $display("FAIL switch_first_pixel: got %h/%b exp abcd/1", vif.out_data, vif.out_vsync); end
    set_ch(2, 1'b1, 1'b1, 16'h5555);
    tick();
    total++; if (vif.out_data !== 16'h5555) begin bad++; $display("FAIL switch_hold: got %h exp 5555", vif.out_data); end
  endtask

  task automatic test_binary();
    logic [DATA_W-1:0] d;
    drive_idle();
    vif.sel = 4'd3;
    tick();
    d = 16'($urandom) | 16'h0001;
    set_ch(3, 1'b1, 1'b1, d);
    tick();
    total++; if (vif.active_sel !== 4'd3) begin bad++; $display("FAIL binary_active: got %0d exp 3", vif.active_sel); end
    total++; if (vif.out_data !== 16'h0000) begin bad++; $display("FAIL binary_edge: got %h exp 0000 (in %h)", vif.out_data, d); end
    d = 16'($urandom) & 16'hFFFE;
    set_ch(3, 1'b1, 1'b0, d);
    tick();
    total++; if (vif.out_data !== 16'hFFFF) begin bad++; $display("FAIL binary_bg: got %h exp ffff (in %h)", vif.out_data, d); end
  endtask

  task automatic test_retarget();
    drive_idle();
    vif.sel = 4'd0;
    tick();
    set_ch(0, 1'b1, 1'b1, 16'h0F0F);
    tick();
    total++; if (vif.active_sel !== 4'd0) begin bad++; $display("FAIL retarget_home: got %0d exp 0", vif.active_sel); end
    drive_idle();
    vif.sel = 4'd4;
    tick();
    vif.sel = 4'd5;
    set_ch(4, 1'b1, 1'b1, 16'h0001);
    tick();
    total++; if (vif.active_sel !== 4'd0 || vif.pending !== 1'b1) begin bad++; $display("FAIL retarget_ignore_old: got active=%0d pending=%b exp 0/1", vif.active_sel, vif.pending); end
    tick();
    set_ch(5, 1'b1, 1'b1, 16'h0000);
    tick();
    total++; if (vif.active_sel !== 4'd5 || vif.out_data !== 16'hFFFF) begin bad++; $display("FAIL retarget_switch: got active=%0d data=%h exp 5/ffff", vif.active_sel, vif.out_data); end
    drive_idle();
    vif.sel = 4'd0;
    tick();
    vif.sel = 4'd5;
    set_ch(0, 1'b1, 1'b1, 16'h7777);
    tick();
    total++; if (vif.pending !== 1'b0 || vif.active_sel !== 4'd5) begin bad++; $display("FAIL cancel: got active=%0d pending=%b exp 5/0", vif.active_sel, vif.pending); end
  endtask

  task automatic test_vsync_already_high();
    drive_idle();
    set_ch(6, 1'b1, 1'b1, 16'h0001);
    tick();
    vif.sel = 4'd6;
    repeat (2) tick();
    total++; if (vif.pending !== 1'b1 || vif.active_sel !== 4'd5) begin bad++; $display("FAIL high_vsync_not_sof: got active=%0d pending=%b exp 5/1", vif.active_sel, vif.pending); end
    set_ch(6, 1'b1, 1'b0, 16'h0001);
    tick();
    set_ch(6, 1'b1, 1'b1, 16'h0001);
    tick();
    total++; if (vif.active_sel !== 4'd6 || vif.out_data !== 16'h0000) begin bad++; $display("FAIL high_vsync_next_edge: got active=%0d data=%h exp 6/0000", vif.active_sel, vif.out_data); end
  endtask

  task automatic test_invalid();
    logic [DATA_W+1:0] e;
    drive_idle();
    set_ch(6, 1'b1, 1'b0, 16'h0000);
    vif.sel = 4'd9;
    tick();
    e = latest_exp();
    total++; if (vif.sel_err !== 1'b1) begin bad++; $display("FAIL invalid_err: got %b exp 1", vif.sel_err); end
    total++; if (vif.active_sel !== 4'd6 || vif.pending !== 1'b0) begin bad++; $display("FAIL invalid_hold: got active=%0d pending=%b exp 6/0", vif.active_sel, vif.pending); end
    total++; if (vif.out_data !== e[DATA_W-1:0]) begin bad++; $display("FAIL invalid_data: got %h exp %h", vif.out_data, e[DATA_W-1:0]); end
    vif.sel = 4'd7;
    tick();
    vif.sel = 4'd9;
    tick();
    total++; if (vif.pending !== 1'b1 || vif.sel_err !== 1'b1) begin bad++; $display("FAIL invalid_while_pending: got pending=%b err=%b exp 1/1", vif.pending, vif.sel_err); end
    set_ch(7, 1'b1, 1'b1, 16'h0001);
    tick();
    total++; if (vif.active_sel !== 4'd7) begin bad++; $display("FAIL invalid_keeps_request: got %0d exp 7", vif.active_sel); end
    vif.sel = 4'd7;
    tick();
    total++; if (vif.sel_err !== 1'b0) begin bad++; $display("FAIL invalid_clear: got %b exp 0", vif.sel_err); end
  endtask

  task automatic test_timeout();
    drive_idle();
    vif.sel = 4'd1;
    repeat (TO_CYC) tick();
    total++; if (vif.pending !== 1'b1) begin bad++; $display("FAIL timeout_wait: got %b exp 1", vif.pending); end
    tick();
    if (TO_EN) begin
      total++; if (vif.pending !== 1'b0 || vif.active_sel !== 4'd1) begin bad++; $display("FAIL timeout_forced: got active=%0d pending=%b exp 1/0", vif.active_sel, vif.pending); end
    end else begin
      total++; if (vif.pending !== 1'b1 || vif.active_sel !== 4'd7) begin bad++; $display("FAIL timeout_none: got active=%0d pending=%b exp 7/1", vif.active_sel, vif.pending); end
    end
  endtask

  task automatic test_reset_mid_pending();
    drive_idle();
    vif.sel = 4'd2;
    tick();
    rst = 1'b1;
    #1 model_reset();
    total++; if (vif.pending !== 1'b0 || vif.active_sel !== 4'd0) begin bad++; $display("FAIL rst_pending: got active=%0d pending=%b exp 0/0", vif.active_sel, vif.pending); end
    tick();
    vif.sel = 4'd0;
    rst = 1'b0;
    set_ch(2, 1'b1, 1'b1, 16'h2222);
    tick();
    total++; if (vif.pending !== 1'b0 || vif.active_sel !== 4'd0) begin bad++; $display("FAIL rst_discard: got active=%0d pending=%b exp 0/0", vif.active_sel, vif.pending); end
  endtask

  task automatic test_random();
    logic [DATA_W+1:0] e;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 19) == 0) vif.sel = 4'($urandom_range(0, 9));
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 7) == 0) vif.in_vsync[c] = ~vif.in_vsync[c];
      vif.in_valid = NUM_CH'($urandom);
      vif.in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      e = latest_exp();
      total++;
      if ({vif.out_valid, vif.out_vsync, vif.out_data} !== e) begin
        bad++; $display("FAIL rand_out@%0d: got %h exp %h", n, {vif.out_valid, vif.out_vsync, vif.out_data}, e);
      end
      total++;
      if (vif.active_sel !== 4'(m_active) || vif.pending !== m_waiting || vif.sel_err !== m_err) begin
        bad++; $display("FAIL rand_ctrl@%0d: got act=%0d pend=%b err=%b exp act=%0d pend=%b err=%b",
                        n, vif.active_sel, vif.pending, vif.sel_err, m_active, m_waiting, m_err);
      end
    end
  endtask

  initial begin
    vif.sel = '0;
    drive_idle();
    test_reset();
    test_switch();
    test_binary();
    test_retarget();
    test_vsync_already_high();
    test_invalid();
    test_timeout();
    test_reset_mid_pending();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/video_stream_selector.md
# video_stream_selector

Parametrised, single-clock video stream selector that routes one of NUM_CH pixel streams (valid/vsync/data) to the display path. Source changes requested on `sel` are deferred to the next frame start of the requested channel so the downstream LCD/HDMI controller never sees a source switch mid-frame from the new source. Binary (edge/morphology) channels are expanded to full width and inverted in-block. The block sits between the processing chains (gray, median, Sobel, Prewitt, erosion, dilation, gesture) and the display controller.

## Interface
Parameters:
- NUM_CH, 8, number of input channels (2..16)
- DATA_W, 16, pixel width (RGB565)
- SEL_W, 4, width of `sel`; must satisfy 2^SEL_W >= NUM_CH
- BIN_MASK, 8'b1111_1000, bit i = 1 marks channel i as 1-bit binary
- DEFAULT_CH, 0, channel active after reset
- TIMEOUT_CYC, 1048576, forced-switch limit (used only with SEL_TIMEOUT_EN)

Ports:
- clk  in  1  pixel clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- sel  in  SEL_W  requested channel index, quasi-static
- in_valid  in  NUM_CH  per-channel pixel valid
- in_vsync  in  NUM_CH  per-channel vsync, active-high
- in_data  in  NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]; binary channels use bit 0 only
- out_valid  out  1  registered valid
- out_vsync  out  1  registered vsync
- out_data  out  DATA_W  registered pixel
- active_sel  out  SEL_W  channel currently forwarded
- pending  out  1  high while a switch is waiting for frame start
- sel_err  out  1  high while `sel` >= NUM_CH

## Operation
- Per-channel vsync delayed one cycle; SOF[i] = in_vsync[i] & ~vsync_d[i].
- States: LOCKED, PENDING. Register pend_sel.
- LOCKED: if sel < NUM_CH and sel != active_sel -> PENDING, pend_sel <= sel. If sel >= NUM_CH: stay, sel_err high, active_sel unchanged.
- PENDING: priority order per cycle:
  1. sel == active_sel -> LOCKED (cancel), no switch.
  2. sel valid and != pend_sel -> pend_sel <= sel, stay PENDING (timer restarts).
  3. SOF[pend_sel] -> active_sel <= pend_sel, LOCKED.
  4. sel invalid -> stay PENDING with old pend_sel, sel_err high.
- Effective channel eff = (state==PENDING && SOF[pend_sel] && rule 3 applies) ? pend_sel : active_sel; the SOF cycle is forwarded from the new channel.
- Data path: out_valid <= in_valid[eff]; out_vsync <= in_vsync[eff]; out_data <= BIN_MASK[eff] ? ~{DATA_W{in_data[eff*DATA_W]}} : in_data[eff].
- Binary pixel 1 (edge) -> 16'h0000, 0 -> 16'hFFFF.
- pending = (state == PENDING).

## Timing
- Reset (async assert, sync release via rst deassert at clk edge): out_valid=0, out_vsync=0, out_data=0, active_sel=DEFAULT_CH, pending=0, sel_err=0, state LOCKED, vsync_d=0, timer=0.
- Latency input -> output: 1 clock.
- Switch latency: sel change seen at edge N -> pending=1 after edge N; switch on edge sampling SOF of requested channel; active_sel updates on that same edge as first new-channel output.
- A vsync already high when the request arrives is not SOF; wait for next rising edge.
- rst mid-PENDING: request discarded, returns to DEFAULT_CH.
- sel_err registered: 1-cycle delay from sel.

## Configuration
- SEL_TIMEOUT_EN defined: counter runs in PENDING, cleared on entry/pend_sel change; at TIMEOUT_CYC-1 switch is forced (as rule 3) regardless of SOF, guarding a dead source. Counter width $clog2(TIMEOUT_CYC).
- Not defined: no counter; PENDING persists until SOF or cancel.

## Test plan
- Reset: rst=1 with random inputs -> all outputs 0, active_sel=0; release, ch0 data 16'h1234 valid -> out_data=16'h1234 one cycle later.
- Switch: active 0, sel=2 -> pending=1, ch0 forwarded; ch2 vsync rises -> same edge active_sel=2, pending=0, ch2 pixel 16'hABCD appears next cycle.
- Binary: sel=3, after SOF, ch3 bit0=1 -> out_data=16'h0000; bit0=0 -> 16'hFFFF.
- Cancel/retarget: active 0, sel=4 then sel=5 before ch4 SOF -> ch4 SOF ignored, switch on ch5 SOF; sel back to 0 while pending -> pending=0, no switch.
- Invalid: NUM_CH=8, sel=9 -> sel_err=1, active_sel stays, output unchanged.
- Timeout (SEL_TIMEOUT_EN, TIMEOUT_CYC=16): sel=1, ch1 vsync held 0 -> forced switch after 16 cycles in PENDING; without macro, pending remains 1.
